// File: rtl/led_pattern_gen.sv
// LED sequencer: rotate-left, rotate-right, ping-pong and bar-fill patterns
// stepped by a speed-selectable prescaler, with pause, single-step and a cycle_done pulse.
module led_pattern_gen #(
   parameter int               LED_NUM        = 4,
   parameter int               CNT_W          = 25,
   parameter logic [CNT_W-1:0] CNT_MAX        = 25'd24_999_999,
   parameter bit               LED_ACTIVE_LOW = 1'b1
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [1:0]         mode,
   input  logic [1:0]         speed_sel,
   input  logic               pause,
   input  logic               step,
   output logic [LED_NUM-1:0] led_out,
   output logic               cycle_done
);

   localparam logic [LED_NUM-1:0] START = LED_NUM'(1);

   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [CNT_W-1:0]   limit;
   logic [LED_NUM-1:0] pattern_reg, pattern_next, step_pattern;
   logic               dir_reg, dir_next, step_dir;
   logic [1:0]         mode_reg;
   logic               cycle_done_reg, cycle_done_next;
   logic               mode_chg, tick, adv;
   logic               is_onehot, is_thermo;

   always_comb begin
      limit    = CNT_MAX >> speed_sel;
      mode_chg = (mode != mode_reg);
      tick     = !pause && (cnt_reg >= limit);
      adv      = tick || (pause && step);

      if (mode_chg)
         cnt_next = '0;
      else if (pause)
         cnt_next = cnt_reg;
      else if (tick)
         cnt_next = '0;
      else
         cnt_next = cnt_reg + CNT_W'(1);
   end

   // Legality of the current pattern for the shift-based modes and for bar-fill
   assign is_onehot = (pattern_reg != '0) && ((pattern_reg & (pattern_reg - LED_NUM'(1))) == '0);
   assign is_thermo = ((pattern_reg & (pattern_reg + LED_NUM'(1))) == '0);

   always_comb begin
      step_pattern = START;
      step_dir     = dir_reg;
      case (mode_reg)
         2'b00: begin
            if (is_onehot)
               step_pattern = {pattern_reg[LED_NUM-2:0], pattern_reg[LED_NUM-1]};
         end
         2'b01: begin
            if (is_onehot)
               step_pattern = {pattern_reg[0], pattern_reg[LED_NUM-1:1]};
         end
         2'b10: begin
            if (!is_onehot) begin
               step_dir = 1'b1;
            end else if (dir_reg) begin
               if (pattern_reg[LED_NUM-1]) begin
                  step_pattern = pattern_reg >> 1;
                  step_dir     = 1'b0;
               end else begin
                  step_pattern = pattern_reg << 1;
               end
            end else begin
               if (pattern_reg[0]) begin
                  step_pattern = pattern_reg << 1;
                  step_dir     = 1'b1;
               end else begin
                  step_pattern = pattern_reg >> 1;
               end
            end
         end
         default: begin
            if (is_thermo) begin
               if (&pattern_reg)
                  step_pattern = '0;
               else
                  step_pattern = {pattern_reg[LED_NUM-2:0], 1'b1};
            end
         end
      endcase
   end

   // Mode change takes priority over any advance in the same cycle
   always_comb begin
      pattern_next    = pattern_reg;
      dir_next        = dir_reg;
      cycle_done_next = 1'b0;
      if (mode_chg) begin
         pattern_next = START;
         dir_next     = 1'b1;
      end else if (adv) begin
         pattern_next    = step_pattern;
         dir_next        = step_dir;
         cycle_done_next = (step_pattern == START);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_reg        <= '0;
         pattern_reg    <= START;
         dir_reg        <= 1'b1;
         mode_reg       <= 2'b00;
         cycle_done_reg <= 1'b0;
      end else begin
         cnt_reg        <= cnt_next;
         pattern_reg    <= pattern_next;
         dir_reg        <= dir_next;
         mode_reg       <= mode;
         cycle_done_reg <= cycle_done_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LED_NUM; gi++) begin : g_led
         assign led_out[gi] = LED_ACTIVE_LOW ? ~pattern_reg[gi] : pattern_reg[gi];
      end
   endgenerate

   assign cycle_done = cycle_done_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen; the reference model tracks a step index
// per mode and derives the expected LED image from it arithmetically.
module tb_led_pattern_gen;

   localparam int N       = 4;
   localparam int CNT_MAX = 3;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n;
   logic [1:0]   mode;
   logic [1:0]   speed_sel;
   logic         pause;
   logic         step;
   logic [N-1:0] led_out;
   logic         cycle_done;

   int checks   = 0;
   int failures = 0;

   int m_k;
   int m_cnt;
   int m_mode_q;
   bit m_done;

   always #5 sys_clk = ~sys_clk;

   led_pattern_gen #(
      .LED_NUM       (N),
      .CNT_W         (25),
      .CNT_MAX       (25'd3),
      .LED_ACTIVE_LOW(1'b1)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .mode      (mode),
      .speed_sel (speed_sel),
      .pause     (pause),
      .step      (step),
      .led_out   (led_out),
      .cycle_done(cycle_done)
   );

   function automatic int period_of(int md);
      case (md)
         0, 1:    return N;
         2:       return 2 * N - 2;
         default: return N + 1;
      endcase
   endfunction

   // Pattern after k advances from the start state
   function automatic logic [N-1:0] ref_pattern(int md, int k);
      int p;
      int pos;
      logic [N-1:0] one;
      one = N'(1);
      case (md)
         0: return one << (k % N);
         1: return one << ((N - (k % N)) % N);
         2: begin
            p   = k % (2 * N - 2);
            pos = (p < N) ? p : (2 * N - 2 - p);
            return one << pos;
         end
         default: begin
            p = (k + 1) % (N + 1);
            return N'((1 << p) - 1);
         end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_k      = 0;
      m_cnt    = 0;
      m_mode_q = 0;
      m_done   = 1'b0;
   endtask

   task automatic model_clock();
      int limit;
      bit tick;
      bit adv;
      limit = CNT_MAX >> speed_sel;
      if (int'(mode) != m_mode_q) begin
         m_k    = 0;
         m_cnt  = 0;
         m_done = 1'b0;
      end else begin
         tick = !pause && (m_cnt >= limit);
         adv  = tick || (pause && step);
         if (!pause)
            m_cnt = tick ? 0 : m_cnt + 1;
         if (adv) begin
            m_k    = (m_k + 1) % period_of(m_mode_q);
            m_done = (m_k == 0);
         end else begin
            m_done = 1'b0;
         end
      end
      m_mode_q = int'(mode);
   endtask

   task automatic check_outputs(input string tag);
      logic [N-1:0] exp_led;
      exp_led = ~ref_pattern(m_mode_q, m_k);
      chk({tag, "_led"}, 32'(led_out), 32'(exp_led));
      chk({tag, "_done"}, 32'(cycle_done), 32'(m_done));
   endtask

   task automatic run_cycle(input string tag);
      @(posedge sys_clk);
      if (sys_rst_n)
         model_clock();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int len;
      int done_cnt;
      sys_rst_n = 1'b0;
      mode      = 2'b00;
      speed_sel = 2'b00;
      pause     = 1'b0;
      step      = 1'b0;
      model_reset();
      #12;
      check_outputs("reset");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // Rotate-left from reset: first advance after limit+1 clocks
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle("rotl_start");
         done_cnt += int'(cycle_done);
      end
      $display("txn rotl_start: 20 clocks, cycle_done pulses=%0d", done_cnt);

      // Paused with three step pulses among 20 clocks
      pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step = (i == 3 || i == 9 || i == 15);
         run_cycle("pause_step");
         #0;
      end
      step  = 1'b0;
      pause = 1'b0;
      for (int i = 0; i < 8; i++) run_cycle("unpause");
      $display("txn pause_step: 3 steps, then resume");

      // Random bursts of mode / speed / pause / step activity
      for (int b = 0; b < 80; b++) begin
         if ($urandom_range(9) < 3) mode = 2'($urandom_range(3));
         if ($urandom_range(9) < 4) speed_sel = 2'($urandom_range(3));
         pause = ($urandom_range(3) == 0);
         len   = $urandom_range(40, 5);
         done_cnt = 0;
         for (int i = 0; i < len; i++) begin
            step = ($urandom_range(3) == 0);
            if ($urandom_range(29) == 0) speed_sel = 2'($urandom_range(3));
            run_cycle("rand");
            done_cnt += int'(cycle_done);
         end
         step = 1'b0;
         $display("txn rand %0d: mode=%0d speed=%0d pause=%0d len=%0d done=%0d",
                  b, mode, speed_sel, pause, len, done_cnt);

         // Asynchronous reset between edges, mid-run
         if (b == 40) begin
            #2;
            sys_rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs("async_rst");
            run_cycle("in_rst");
            run_cycle("in_rst");
            sys_rst_n = 1'b1;
            $display("txn async_rst: reset asserted between clock edges");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
